rv_multicycle_controller: RTL
=============================

Name: rv_multicycle_controller

Overview:
- Control unit for the multi-cycle RISC-V core, the successor to the single-cycle decoder.
- A Moore FSM sequences fetch, decode, execute, memory and writeback over several cycles, with a ready/request handshake to a shared instruction/data memory.
- Adds a 4-bit ALU control (RV32I ALU ops), six branch conditions and illegal-opcode detection.
- Sits between the instruction register and the multi-cycle datapath.

Parameters:
- ALUCTRL_W, 4, width of o_alucrtl. Must be ≥4.
- IMMSRC_W, 3, width of o_immsrc. Encodes I/S/B/J/U.
- MEM_WAIT_EN, 1, 1 = memory states wait for i_mem_ready; 0 = i_mem_ready treated as constant 1.
- STATE_W, 4, width of o_state (debug).

Ports:
- i_clk  in  1  clock, rising edge
- i_rst  in  1  reset; one clock; reset is asynchronous and active-high
- i_op  in  7  opcode from instruction register
- i_funct3  in  3  funct3 field
- i_funct7b5  in  1  funct7 bit 5
- i_zero  in  1  ALU result == 0
- i_lt  in  1  signed A<B from ALU
- i_ltu  in  1  unsigned A<B from ALU
- i_mem_ready  in  1  memory completes the access this cycle
- o_mem_req  out  1  memory access requested
- o_memwrite  out  1  data memory write strobe
- o_adrsrc  out  1  0 = PC, 1 = ALUOut as memory address
- o_irwrite  out  1  load instruction register and OldPC
- o_pcwrite  out  1  PC update enable
- o_regwrite  out  1  register file write enable
- o_resultsrc  out  2  00 ALUOut, 01 Data, 10 ALUResult, 11 ImmExt
- o_alusrca  out  2  00 PC, 01 OldPC, 10 rs1
- o_alusrcb  out  2  00 rs2, 01 ImmExt, 10 constant 4
- o_immsrc  out  IMMSRC_W  000 I, 001 S, 010 B, 011 J, 100 U
- o_alucrtl  out  ALUCTRL_W  ALU operation
- o_illegal  out  1  one-cycle pulse on an unsupported opcode or funct3
- o_state  out  STATE_W  current state (debug)

Behaviour:
- States:
  - FETCH: req=1, adrsrc=0, A=PC, B=4, alu=ADD, resultsrc=10. On ready: irwrite=1, pcwrite=1, go to DECODE; else stay.
  - DECODE: A=OldPC, B=Imm, immsrc=B, alu=ADD (branch target into ALUOut).
  - From DECODE by opcode: lw/sw→MEMADR; R→EXECR; I-ALU→EXECI; branch→BRANCH; jal→JAL; jalr→JALR; lui→LUI; otherwise o_illegal=1 and go to FETCH with no writes.
  - MEMADR: A=rs1, B=Imm, immsrc I (lw) or S (sw), ADD. Goes to MEMREAD (lw) or MEMWRITE (sw).
  - MEMREAD: req=1, adrsrc=1. On ready go to MEMWB; else stay.
  - MEMWB: resultsrc=01, regwrite=1, then FETCH.
  - MEMWRITE: req=1, adrsrc=1, memwrite=1 held until ready, then FETCH.
  - EXECR / EXECI: A=rs1, B=rs2 or Imm, ALU decode, then ALUWB.
  - ALUWB: resultsrc=00, regwrite=1, then FETCH.
  - BRANCH: A=rs1, B=rs2, SUB, resultsrc=00, pcwrite=cond, then FETCH.
  - JAL: A=OldPC, B=4, ADD, resultsrc=00, pcwrite=1. Next is ALUWB, which writes PC+4 to rd.
  - JALR: A=rs1, B=Imm, ADD, then JALPC. JALPC: pcwrite=1 from ALUOut, then a state that writes OldPC+4. Both sub-states are included in the 4-bit encoding.
  - LUI: immsrc=U, resultsrc=11, regwrite=1, then FETCH.
- Branch condition by funct3:
  - 000 zero
  - 001 !zero
  - 100 lt
  - 101 !lt
  - 110 ltu
  - 111 !ltu
  - 010/011 → illegal pulse, no pcwrite.
- ALU codes:
  - 0000 ADD, 0001 SUB, 0010 AND, 0011 OR, 0100 XOR, 0101 SLT, 0110 SLTU, 0111 SLL, 1000 SRL, 1001 SRA.
  - SUB only for R-type with funct7b5=1. SRA when funct3=101 and funct7b5=1 (R or I).
- Output timing:
  - Outputs are combinational from state.
  - irwrite, pcwrite (FETCH) and the MEMREAD/MEMWRITE exits are additionally gated by i_mem_ready.
  - All unlisted outputs are 0 in each state.
- Reset:
  - Asynchronous; state becomes FETCH immediately.
  - While i_rst=1, all write enables and req are forced 0, and o_illegal=0.
  - Reset mid-access abandons the transaction.
- i_mem_ready outside a requesting state is ignored.

Decomposition:
- Package rv_mc_pkg holds:
  - state enum
  - opcode constants
  - ALU code constants
  - immsrc / resultsrc / alusrca / alusrcb encodings
- One sub-module, rv_mc_aludec: combinational; inputs are ALU-op class, funct3, funct7b5 and opb5; output is o_alucrtl.

Test Plan:
- Reset and lw: i_rst pulse with ready=1, then lw (op 0000011) → o_state sequence FETCH, DECODE, MEMADR, MEMREAD, MEMWB, FETCH; regwrite=1 only in MEMWB with resultsrc=01.
- Wait states: FETCH with ready low for 3 cycles → req=1 for 4 cycles; irwrite and pcwrite each high exactly 1 cycle.
- R-type: sub (funct3 000, f7b5=1) → alucrtl=0001; sra (101, 1) → 1001; addi with f7b5=1 → 0000.
- Branches:
  - bne with zero=1 → pcwrite=0.
  - bltu with ltu=1 → pcwrite=1.
  - funct3=010 → illegal pulse, no writes.
- Illegal opcode: op 1111111 → o_illegal one cycle in DECODE, then FETCH; regwrite, memwrite and pcwrite all 0.
- Reset mid-MEMWRITE (ready=0) → memwrite and req drop asynchronously; after release, state=FETCH.

Source files
------------

// File: rtl/rv_mc_pkg.sv
// Shared types and encodings for the multi-cycle RISC-V controller.
// Latency: n/a (definitions only).
// Backpressure: n/a.
package rv_mc_pkg;

  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADR   = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXECR    = 4'd6,
    S_EXECI    = 4'd7,
    S_ALUWB    = 4'd8,
    S_BRANCH   = 4'd9,
    S_JAL      = 4'd10,
    S_JALR     = 4'd11,
    S_JALPC    = 4'd12,
    S_LUI      = 4'd13
  } state_t;

  // ALU operation class handed from the FSM to the ALU decoder
  typedef enum logic [1:0] {
    ALUOP_ADD   = 2'b00,
    ALUOP_SUB   = 2'b01,
    ALUOP_FUNCT = 2'b10
  } aluop_t;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_LUI    = 7'b0110111;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_J = 3'b011;
  localparam logic [2:0] IMM_U = 3'b100;

  localparam logic [1:0] RES_ALUOUT = 2'b00;
  localparam logic [1:0] RES_DATA   = 2'b01;
  localparam logic [1:0] RES_ALURES = 2'b10;
  localparam logic [1:0] RES_IMM    = 2'b11;

  localparam logic [1:0] SRCA_PC    = 2'b00;
  localparam logic [1:0] SRCA_OLDPC = 2'b01;
  localparam logic [1:0] SRCA_RS1   = 2'b10;

  localparam logic [1:0] SRCB_RS2  = 2'b00;
  localparam logic [1:0] SRCB_IMM  = 2'b01;
  localparam logic [1:0] SRCB_FOUR = 2'b10;

endpackage

// File: rtl/rv_mc_aludec.sv
// ALU decoder: maps ALU-op class plus funct3/funct7b5/opb5 to an RV32I ALU code.
// Latency: combinational. Backpressure: none.
// Ports: aluop (class), funct3, funct7b5, opb5 (1 = R-type) -> alucrtl.
module rv_mc_aludec
  import rv_mc_pkg::*;
#(
  parameter int ALUCTRL_W = 4
) (
  input  aluop_t               aluop,
  input  logic [2:0]           funct3,
  input  logic                 funct7b5,
  input  logic                 opb5,
  output logic [ALUCTRL_W-1:0] alucrtl
);

  logic [3:0] ctrl;

  always_comb begin
    ctrl = ALU_ADD;
    case (aluop)
      ALUOP_ADD: ctrl = ALU_ADD;
      ALUOP_SUB: ctrl = ALU_SUB;
      default: begin
        case (funct3)
          // funct7b5 on an I-type add is immediate bits, so only R-type subtracts
          3'b000:  ctrl = (opb5 && funct7b5) ? ALU_SUB : ALU_ADD;
          3'b001:  ctrl = ALU_SLL;
          3'b010:  ctrl = ALU_SLT;
          3'b011:  ctrl = ALU_SLTU;
          3'b100:  ctrl = ALU_XOR;
          3'b101:  ctrl = funct7b5 ? ALU_SRA : ALU_SRL;
          3'b110:  ctrl = ALU_OR;
          default: ctrl = ALU_AND;
        endcase
      end
    endcase
  end

  assign alucrtl = ALUCTRL_W'(ctrl);

endmodule

// File: rtl/rv_multicycle_controller.sv
// Multi-cycle RISC-V control FSM: fetch/decode/execute/memory/writeback sequencing.
// Latency: Moore outputs from state; 3-5 cycles per instruction plus memory waits.
// Backpressure: FETCH/MEMREAD/MEMWRITE hold (req asserted) until i_mem_ready.
// Ports: i_op/i_funct3/i_funct7b5 from IR, i_zero/i_lt/i_ltu flags from ALU,
//   i_mem_ready memory handshake; o_* datapath controls, o_illegal pulse, o_state debug.
module rv_multicycle_controller
  import rv_mc_pkg::*;
#(
  parameter int ALUCTRL_W   = 4,
  parameter int IMMSRC_W    = 3,
  parameter int MEM_WAIT_EN = 1,
  parameter int STATE_W     = 4
) (
  input  logic                 i_clk,
  input  logic                 i_rst,
  input  logic [6:0]           i_op,
  input  logic [2:0]           i_funct3,
  input  logic                 i_funct7b5,
  input  logic                 i_zero,
  input  logic                 i_lt,
  input  logic                 i_ltu,
  input  logic                 i_mem_ready,
  output logic                 o_mem_req,
  output logic                 o_memwrite,
  output logic                 o_adrsrc,
  output logic                 o_irwrite,
  output logic                 o_pcwrite,
  output logic                 o_regwrite,
  output logic [1:0]           o_resultsrc,
  output logic [1:0]           o_alusrca,
  output logic [1:0]           o_alusrcb,
  output logic [IMMSRC_W-1:0]  o_immsrc,
  output logic [ALUCTRL_W-1:0] o_alucrtl,
  output logic                 o_illegal,
  output logic [STATE_W-1:0]   o_state
);

  state_t     state, state_next;
  aluop_t     aluop;
  logic       ready, br_bad, br_take;
  logic       mem_req, memwrite, irwrite, pcwrite, regwrite, illegal;
  logic [2:0] immsrc;

  assign ready = (MEM_WAIT_EN != 0) ? i_mem_ready : 1'b1;

  // funct3 010/011 have no branch meaning; others: bit0 inverts the base test
  assign br_bad = (i_funct3[2:1] == 2'b01);
  always_comb begin
    case (i_funct3[2:1])
      2'b00:   br_take = i_zero ^ i_funct3[0];
      2'b10:   br_take = i_lt   ^ i_funct3[0];
      2'b11:   br_take = i_ltu  ^ i_funct3[0];
      default: br_take = 1'b0;
    endcase
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) state <= S_FETCH;
    else       state <= state_next;
  end

  always_comb begin
    state_next  = state;
    mem_req     = 1'b0;
    memwrite    = 1'b0;
    o_adrsrc    = 1'b0;
    irwrite     = 1'b0;
    pcwrite     = 1'b0;
    regwrite    = 1'b0;
    illegal     = 1'b0;
    o_resultsrc = RES_ALUOUT;
    o_alusrca   = SRCA_PC;
    o_alusrcb   = SRCB_RS2;
    immsrc      = IMM_I;
    aluop       = ALUOP_ADD;
    case (state)
      S_FETCH: begin
        mem_req     = 1'b1;
        o_alusrcb   = SRCB_FOUR;
        o_resultsrc = RES_ALURES;
        irwrite     = ready;
        pcwrite     = ready;
        if (ready) state_next = S_DECODE;
      end
      S_DECODE: begin
        // precompute the branch/jump target into ALUOut; jal needs the J immediate
        o_alusrca = SRCA_OLDPC;
        o_alusrcb = SRCB_IMM;
        immsrc    = (i_op == OP_JAL) ? IMM_J : IMM_B;
        case (i_op)
          OP_LOAD, OP_STORE: state_next = S_MEMADR;
          OP_RTYPE:          state_next = S_EXECR;
          OP_ITYPE:          state_next = S_EXECI;
          OP_BRANCH:         state_next = S_BRANCH;
          OP_JAL:            state_next = S_JAL;
          OP_JALR:           state_next = S_JALR;
          OP_LUI:            state_next = S_LUI;
          default: begin
            illegal    = 1'b1;
            state_next = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        o_alusrca  = SRCA_RS1;
        o_alusrcb  = SRCB_IMM;
        immsrc     = (i_op == OP_STORE) ? IMM_S : IMM_I;
        state_next = (i_op == OP_STORE) ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        mem_req  = 1'b1;
        o_adrsrc = 1'b1;
        if (ready) state_next = S_MEMWB;
      end
      S_MEMWB: begin
        o_resultsrc = RES_DATA;
        regwrite    = 1'b1;
        state_next  = S_FETCH;
      end
      S_MEMWRITE: begin
        mem_req  = 1'b1;
        o_adrsrc = 1'b1;
        memwrite = 1'b1;
        if (ready) state_next = S_FETCH;
      end
      S_EXECR: begin
        o_alusrca  = SRCA_RS1;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_EXECI: begin
        o_alusrca  = SRCA_RS1;
        o_alusrcb  = SRCB_IMM;
        aluop      = ALUOP_FUNCT;
        state_next = S_ALUWB;
      end
      S_ALUWB: begin
        regwrite   = 1'b1;
        state_next = S_FETCH;
      end
      S_BRANCH: begin
        o_alusrca  = SRCA_RS1;
        aluop      = ALUOP_SUB;
        illegal    = br_bad;
        pcwrite    = br_take && !br_bad;
        state_next = S_FETCH;
      end
      S_JAL: begin
        // PC <- target in ALUOut while ALU forms OldPC+4 for the link write
        o_alusrca  = SRCA_OLDPC;
        o_alusrcb  = SRCB_FOUR;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_JALR: begin
        o_alusrca  = SRCA_RS1;
        o_alusrcb  = SRCB_IMM;
        state_next = S_JALPC;
      end
      S_JALPC: begin
        o_alusrca  = SRCA_OLDPC;
        o_alusrcb  = SRCB_FOUR;
        pcwrite    = 1'b1;
        state_next = S_ALUWB;
      end
      S_LUI: begin
        immsrc      = IMM_U;
        o_resultsrc = RES_IMM;
        regwrite    = 1'b1;
        state_next  = S_FETCH;
      end
      default: state_next = S_FETCH;
    endcase
  end

  rv_mc_aludec #(.ALUCTRL_W(ALUCTRL_W)) u_aludec (
    .aluop    (aluop),
    .funct3   (i_funct3),
    .funct7b5 (i_funct7b5),
    .opb5     (i_op[5]),
    .alucrtl  (o_alucrtl)
  );

  // reset must silence strobes immediately, even though FETCH itself requests
  assign o_mem_req  = mem_req  & ~i_rst;
  assign o_memwrite = memwrite & ~i_rst;
  assign o_irwrite  = irwrite  & ~i_rst;
  assign o_pcwrite  = pcwrite  & ~i_rst;
  assign o_regwrite = regwrite & ~i_rst;
  assign o_illegal  = illegal  & ~i_rst;
  assign o_immsrc   = IMMSRC_W'(immsrc);
  assign o_state    = STATE_W'(state);

endmodule
